// File: rtl/display_scan_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_scan_scheduler_pkg
//  Description : Shared types and constants for the multiplexed digit scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
package display_scan_scheduler_pkg;

    localparam int c_CODE_W = 4;
    localparam logic [c_CODE_W-1:0] c_BLANK_CODE = 4'h0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/display_scan_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : display_scan_scheduler_if
//  Description : Content inputs and scan outputs of the digit scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
interface display_scan_scheduler_if #(
    parameter int NUM_DIGITS = 6
);
    import display_scan_scheduler_pkg::*;

    logic                             enable;
    logic                             load;
    logic [c_CODE_W*NUM_DIGITS-1:0]   digits_in;
    logic [NUM_DIGITS-1:0]            blank_mask;
    logic [NUM_DIGITS-1:0]            blink_mask;
    logic [c_CODE_W-1:0]              digit_code;
    logic                             seg_off;
    logic [NUM_DIGITS-1:0]            digit_sel_n;
    logic                             frame_start;

    modport master (
        output enable, load, digits_in, blank_mask, blink_mask,
        input  digit_code, seg_off, digit_sel_n, frame_start
    );

    modport slave (
        input  enable, load, digits_in, blank_mask, blink_mask,
        output digit_code, seg_off, digit_sel_n, frame_start
    );

endinterface
`default_nettype wire

// File: rtl/display_scan_scheduler_scan_timebase.sv
`default_nettype none
// ============================================================================
//  Module      : scan_timebase
//  Description : Cycle-in-slot and slot counters with slot/frame end strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_timebase #(
    parameter int NUM_DIGITS   = 6,
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD_CYCLES = 16,
    parameter int SLOT_W       = 3
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_advance,
    output logic [SLOT_W-1:0]      o_slot_nxt,
    output logic                   o_guard_end,
    output logic                   o_slot_end,
    output logic                   o_frame_end
);

    localparam int c_CNT_W = $clog2(SCAN_DIV);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST   = c_CNT_W'(SCAN_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_GUARD_LAST = c_CNT_W'(GUARD_CYCLES - 1);
    localparam logic [SLOT_W-1:0]  c_SLOT_LAST  = SLOT_W'(NUM_DIGITS - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [SLOT_W-1:0]  r_slot;
    logic [SLOT_W-1:0]  w_slot_nxt;
    logic               w_cnt_last;
    logic               w_slot_last;

    assign w_cnt_last  = (r_cnt == c_CNT_LAST);
    assign w_slot_last = (r_slot == c_SLOT_LAST);

    // Counters fall back to slot 0 / cycle 0 whenever scanning is not advancing.
    always_comb begin
        w_cnt_nxt  = '0;
        w_slot_nxt = '0;
        if (i_advance) begin
            w_cnt_nxt  = w_cnt_last ? '0 : r_cnt + c_CNT_W'(1);
            w_slot_nxt = r_slot;
            if (w_cnt_last) begin
                w_slot_nxt = w_slot_last ? '0 : r_slot + SLOT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_slot <= '0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_slot <= w_slot_nxt;
        end
    end

    assign o_slot_nxt  = w_slot_nxt;
    assign o_guard_end = i_advance && (r_cnt == c_GUARD_LAST);
    assign o_slot_end  = i_advance && w_cnt_last;
    assign o_frame_end = i_advance && w_cnt_last && w_slot_last;

endmodule
`default_nettype wire

// File: rtl/display_scan_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : display_scan_scheduler
//  Description : Scans digits through one shared 7-segment decoder with guard
//                intervals, frame-aligned content updates and blinking.
//  Revision    : 1.0 - initial release
// ============================================================================
module display_scan_scheduler
    import display_scan_scheduler_pkg::*;
#(
    parameter int NUM_DIGITS   = 6,
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD_CYCLES = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  wire logic               clk,
    input  wire logic               reset,
    display_scan_scheduler_if.slave bus
);

    localparam int c_SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_DIG_W  = c_CODE_W * NUM_DIGITS;
    localparam int c_FRM_W  = $clog2(BLINK_FRAMES + 1);
    localparam logic [c_FRM_W-1:0] c_FRM_LAST = c_FRM_W'(BLINK_FRAMES - 1);

    scan_state_t           r_state, w_state_nxt;
    logic [c_DIG_W-1:0]    r_act_digits, w_act_digits_nxt;
    logic [NUM_DIGITS-1:0] r_act_blank, w_act_blank_nxt;
    logic [NUM_DIGITS-1:0] r_act_blink, w_act_blink_nxt;
    logic [c_DIG_W-1:0]    r_pend_digits, w_pend_digits_nxt;
    logic [NUM_DIGITS-1:0] r_pend_blank, w_pend_blank_nxt;
    logic [NUM_DIGITS-1:0] r_pend_blink, w_pend_blink_nxt;
    logic                  r_pend_valid, w_pend_valid_nxt;
    logic [c_FRM_W-1:0]    r_frm_cnt, w_frm_cnt_nxt;
    logic                  r_blink_phase, w_blink_phase_nxt;

    logic [c_CODE_W-1:0]   r_digit_code, w_digit_code_nxt;
    logic                  r_seg_off, w_seg_off_nxt;
    logic [NUM_DIGITS-1:0] r_digit_sel_n, w_digit_sel_n_nxt;
    logic                  r_frame_start, w_frame_start_nxt;

    logic                  w_advance;
    logic                  w_wrap;
    logic                  w_drop;
    logic [c_SLOT_W-1:0]   w_slot_nxt;
    logic                  w_guard_end;
    logic                  w_slot_end;
    logic                  w_frame_end;
    logic [c_CODE_W-1:0]   w_sel_code;
    logic                  w_sel_off;
    logic [NUM_DIGITS-1:0] w_onehot_n;

    assign w_advance = (r_state != ST_IDLE) && bus.enable;
    assign w_wrap    = (r_state == ST_SHOW) && w_frame_end;
    assign w_drop    = (r_state != ST_IDLE) && !bus.enable;

    scan_timebase #(
        .NUM_DIGITS   (NUM_DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .GUARD_CYCLES (GUARD_CYCLES),
        .SLOT_W       (c_SLOT_W)
    ) u_timebase (
        .clk         (clk),
        .rst         (reset),
        .i_advance   (w_advance),
        .o_slot_nxt  (w_slot_nxt),
        .o_guard_end (w_guard_end),
        .o_slot_end  (w_slot_end),
        .o_frame_end (w_frame_end)
    );

    always_comb begin
        w_state_nxt       = r_state;
        w_frame_start_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.enable) begin
                    w_state_nxt       = ST_GUARD;
                    w_frame_start_nxt = 1'b1;
                end
            end
            ST_GUARD: begin
                if (!bus.enable)     w_state_nxt = ST_IDLE;
                else if (w_guard_end) w_state_nxt = ST_SHOW;
            end
            ST_SHOW: begin
                if (!bus.enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_slot_end) begin
                    w_state_nxt       = ST_GUARD;
                    w_frame_start_nxt = w_frame_end;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Idle loads go straight to the display; otherwise they wait for a frame
    // boundary (or a drop to idle) so a frame is never shown half-updated.
    always_comb begin
        w_act_digits_nxt  = r_act_digits;
        w_act_blank_nxt   = r_act_blank;
        w_act_blink_nxt   = r_act_blink;
        w_pend_digits_nxt = r_pend_digits;
        w_pend_blank_nxt  = r_pend_blank;
        w_pend_blink_nxt  = r_pend_blink;
        w_pend_valid_nxt  = r_pend_valid;
        if (r_state == ST_IDLE) begin
            if (bus.load) begin
                w_act_digits_nxt = bus.digits_in;
                w_act_blank_nxt  = bus.blank_mask;
                w_act_blink_nxt  = bus.blink_mask;
            end
        end else begin
            if (r_pend_valid && (w_wrap || w_drop)) begin
                w_act_digits_nxt = r_pend_digits;
                w_act_blank_nxt  = r_pend_blank;
                w_act_blink_nxt  = r_pend_blink;
                w_pend_valid_nxt = 1'b0;
            end
            if (bus.load) begin
                w_pend_digits_nxt = bus.digits_in;
                w_pend_blank_nxt  = bus.blank_mask;
                w_pend_blink_nxt  = bus.blink_mask;
                w_pend_valid_nxt  = 1'b1;
            end
        end
    end

    always_comb begin
        w_frm_cnt_nxt     = r_frm_cnt;
        w_blink_phase_nxt = r_blink_phase;
        if (w_wrap) begin
            if (r_frm_cnt == c_FRM_LAST) begin
                w_frm_cnt_nxt     = '0;
                w_blink_phase_nxt = ~r_blink_phase;
            end else begin
                w_frm_cnt_nxt = r_frm_cnt + c_FRM_W'(1);
            end
        end else if (w_drop) begin
            w_frm_cnt_nxt = '0;
        end
    end

    // Outputs are derived from next-state values so they register in step.
    always_comb begin
        w_sel_code = c_BLANK_CODE;
        w_sel_off  = 1'b1;
        w_onehot_n = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_slot_nxt == c_SLOT_W'(i)) begin
                w_sel_code    = w_act_digits_nxt[i*c_CODE_W +: c_CODE_W];
                w_sel_off     = w_act_blank_nxt[i] | (w_act_blink_nxt[i] & w_blink_phase_nxt);
                w_onehot_n[i] = 1'b0;
            end
        end
    end

    always_comb begin
        w_digit_code_nxt  = c_BLANK_CODE;
        w_seg_off_nxt     = 1'b1;
        w_digit_sel_n_nxt = '1;
        case (w_state_nxt)
            ST_GUARD: w_digit_code_nxt = w_sel_code;
            ST_SHOW: begin
                w_digit_code_nxt  = w_sel_code;
                w_seg_off_nxt     = w_sel_off;
                w_digit_sel_n_nxt = w_onehot_n;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_act_digits  <= '0;
            r_act_blank   <= '0;
            r_act_blink   <= '0;
            r_pend_digits <= '0;
            r_pend_blank  <= '0;
            r_pend_blink  <= '0;
            r_pend_valid  <= 1'b0;
            r_frm_cnt     <= '0;
            r_blink_phase <= 1'b0;
            r_digit_code  <= c_BLANK_CODE;
            r_seg_off     <= 1'b1;
            r_digit_sel_n <= '1;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_act_digits  <= w_act_digits_nxt;
            r_act_blank   <= w_act_blank_nxt;
            r_act_blink   <= w_act_blink_nxt;
            r_pend_digits <= w_pend_digits_nxt;
            r_pend_blank  <= w_pend_blank_nxt;
            r_pend_blink  <= w_pend_blink_nxt;
            r_pend_valid  <= w_pend_valid_nxt;
            r_frm_cnt     <= w_frm_cnt_nxt;
            r_blink_phase <= w_blink_phase_nxt;
            r_digit_code  <= w_digit_code_nxt;
            r_seg_off     <= w_seg_off_nxt;
            r_digit_sel_n <= w_digit_sel_n_nxt;
            r_frame_start <= w_frame_start_nxt;
        end
    end

    assign bus.digit_code  = r_digit_code;
    assign bus.seg_off     = r_seg_off;
    assign bus.digit_sel_n = r_digit_sel_n;
    assign bus.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_scan_scheduler
//  Description : Directed self-checking bench for display_scan_scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan_scheduler;

    localparam int ND    = 4;
    localparam int SD    = 8;
    localparam int GC    = 2;
    localparam int BF    = 2;
    localparam int FRAME = ND * SD;
    // {frame_start, seg_off, digit_sel_n, digit_code} while dark/idle
    localparam logic [9:0] c_IDLE_OUT = 10'b0_1_1111_0000;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    display_scan_scheduler_if #(.NUM_DIGITS(ND)) bus ();

    display_scan_scheduler #(
        .NUM_DIGITS   (ND),
        .SCAN_DIV     (SD),
        .GUARD_CYCLES (GC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [9:0] obs;
    assign obs = {bus.frame_start, bus.seg_off, bus.digit_sel_n, bus.digit_code};

    // Expected outputs c cycles after the enabling edge, from a fresh reset.
    function automatic logic [9:0] exp_out(input int c, input logic [15:0] d,
                                           input logic [3:0] bl, input logic [3:0] bk);
        int fc, slot, pos, ph;
        logic [3:0] code, sel;
        logic off, fs;
        fc   = c % FRAME;
        slot = fc / SD;
        pos  = fc % SD;
        ph   = ((c / FRAME) / BF) % 2;
        fs   = (fc == 0);
        code = d[slot*4 +: 4];
        sel  = 4'hF;
        off  = 1'b1;
        if (pos >= GC) begin
            sel[slot] = 1'b0;
            off = bl[slot] | (bk[slot] & (ph == 1));
        end
        return {fs, off, sel, code};
    endfunction

    task automatic start(input logic [15:0] d, input logic [3:0] bl, input logic [3:0] bk);
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.load = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus.digits_in = d;
        bus.blank_mask = bl;
        bus.blink_mask = bk;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        bus.enable = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.enable = 1'b1;
        bus.load = 1'b1;
        bus.digits_in = 16'hFFFF;
        bus.blank_mask = 4'h0;
        bus.blink_mask = 4'h0;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.digit_code !== 4'h0) begin n_bad++; $display("FAIL reset_code got %h want 0", bus.digit_code); end
        n_cmp++; if (bus.seg_off !== 1'b1) begin n_bad++; $display("FAIL reset_segoff got %b want 1", bus.seg_off); end
        n_cmp++; if (bus.digit_sel_n !== 4'hF) begin n_bad++; $display("FAIL reset_sel got %b want 1111", bus.digit_sel_n); end
        n_cmp++; if (bus.frame_start !== 1'b0) begin n_bad++; $display("FAIL reset_fs got %b want 0", bus.frame_start); end
        bus.enable = 1'b0;
        bus.load = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (obs !== c_IDLE_OUT) begin n_bad++; $display("FAIL idle_after_reset got %b want %b", obs, c_IDLE_OUT); end
    endtask

    task automatic test_scan;
        logic [9:0] e;
        start(16'h1234, 4'h0, 4'h0);
        n_cmp++; if (obs !== 10'b1_1_1111_0100) begin n_bad++; $display("FAIL scan_first got %b want 1111110100", obs); end
        for (int c = 0; c < 2*FRAME; c++) begin
            e = exp_out(c, 16'h1234, 4'h0, 4'h0);
            n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL scan c=%0d got %b want %b", c, obs, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_midframe_load;
        logic [9:0] e;
        start(16'h1234, 4'h0, 4'h0);
        for (int c = 0; c < 2*FRAME; c++) begin
            e = exp_out(c, (c < FRAME) ? 16'h1234 : 16'h5678, 4'h0, 4'h0);
            n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL midload c=%0d got %b want %b", c, obs, e); end
            if (c == 10) begin bus.digits_in = 16'h5678; bus.load = 1'b1; end
            if (c == 11) bus.load = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] e;
        logic [15:0] d;
        start(16'h1234, 4'h0, 4'h0);
        for (int c = 0; c < 3*FRAME; c++) begin
            d = (c < FRAME) ? 16'h1234 : (c < 2*FRAME) ? 16'h2222 : 16'hABCD;
            e = exp_out(c, d, 4'h0, 4'h0);
            n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL b2b c=%0d got %b want %b", c, obs, e); end
            bus.load = 1'b0;
            if (c == 5)  begin bus.digits_in = 16'h1111; bus.load = 1'b1; end
            if (c == 20) begin bus.digits_in = 16'h2222; bus.load = 1'b1; end
            if (c == FRAME-1) begin bus.digits_in = 16'hABCD; bus.load = 1'b1; end
            @(negedge clk);
        end
    endtask

    task automatic test_blink_blank;
        logic [9:0] e;
        start(16'h1234, 4'b0100, 4'b0001);
        for (int c = 0; c < 4*FRAME; c++) begin
            e = exp_out(c, 16'h1234, 4'b0100, 4'b0001);
            n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL blink c=%0d got %b want %b", c, obs, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_enable_drop;
        logic [9:0] e;
        start(16'h1234, 4'h0, 4'h0);
        for (int c = 0; c <= 20; c++) begin
            e = exp_out(c, 16'h1234, 4'h0, 4'h0);
            n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL drop_pre c=%0d got %b want %b", c, obs, e); end
            if (c == 12) begin bus.digits_in = 16'h5678; bus.load = 1'b1; end
            if (c == 13) bus.load = 1'b0;
            if (c == 20) bus.enable = 1'b0;
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (obs !== c_IDLE_OUT) begin n_bad++; $display("FAIL drop_idle k=%0d got %b want %b", k, obs, c_IDLE_OUT); end
            @(negedge clk);
        end
        bus.enable = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            e = exp_out(c, 16'h5678, 4'h0, 4'h0);
            n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL drop_restart c=%0d got %b want %b", c, obs, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midshow;
        logic [9:0] e;
        start(16'h1234, 4'h0, 4'h0);
        for (int c = 0; c <= 20; c++) begin
            e = exp_out(c, 16'h1234, 4'h0, 4'h0);
            n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL rstmid_pre c=%0d got %b want %b", c, obs, e); end
            if (c == 12) begin bus.digits_in = 16'h9999; bus.load = 1'b1; end
            if (c == 13) bus.load = 1'b0;
            if (c == 20) begin reset = 1'b1; bus.enable = 1'b0; end
            @(negedge clk);
        end
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (obs !== c_IDLE_OUT) begin n_bad++; $display("FAIL rstmid_idle k=%0d got %b want %b", k, obs, c_IDLE_OUT); end
            @(negedge clk);
        end
        bus.enable = 1'b1;
        @(negedge clk);
        for (int c = 0; c < FRAME + 10; c++) begin
            e = exp_out(c, 16'h0000, 4'h0, 4'h0);
            n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL rstmid_after c=%0d got %b want %b", c, obs, e); end
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.load = 1'b0;
        bus.digits_in = '0;
        bus.blank_mask = '0;
        bus.blink_mask = '0;
        @(negedge clk);
        test_reset();
        test_scan();
        test_midframe_load();
        test_back_to_back();
        test_blink_blank();
        test_enable_drop();
        test_reset_midshow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
